// File: rtl/sim_clk_ce_ratio.sv
// Rational clock-enable generator: one-cycle ce pulses at an average rate of mult/div of clk_in.
// Optional: define SIM_CLK_CE_STATS_EN to build the 32-bit ce_count pulse counter.
module sim_clk_ce_ratio #(
    parameter int WIDTH      = 16,
    parameter int DEF_MULT   = 3,
    parameter int DEF_DIV    = 5,
    parameter int SKIP_FIRST = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             set_ratio,
    input  logic [WIDTH-1:0] mult_in,
    input  logic [WIDTH-1:0] div_in,
    output logic             ce,
    output logic             pending,
    output logic             err,
    output logic [31:0]      ce_count
);

    localparam int SKW = (SKIP_FIRST > 0) ? $clog2(SKIP_FIRST + 1) : 1;

    logic [WIDTH-1:0] mult_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] pend_mult_q;
    logic [WIDTH-1:0] pend_div_q;
    logic [SKW-1:0]   skip_q;

    logic [WIDTH:0]   sum;
    logic             hit;
    logic [WIDTH-1:0] acc_nxt;
    logic [SKW-1:0]   skip_nxt;
    logic             boundary;
    logic             load_ok;

    // Carry bit kept so mult close to 2**WIDTH never wraps the comparison.
    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, mult_q};
        hit      = 1'b0;
        acc_nxt  = '0;
        skip_nxt = skip_q;
        if (en) begin
            hit = (sum >= {1'b0, div_q});
            if (hit) begin
                acc_nxt = WIDTH'(sum - {1'b0, div_q});
            end else begin
                acc_nxt = sum[WIDTH-1:0];
            end
            if (hit && (skip_q != '0)) begin
                skip_nxt = skip_q - 1'b1;
            end
        end else begin
            skip_nxt = SKW'(SKIP_FIRST);
        end
        // A ratio may only change where the pattern restarts from acc = 0.
        boundary = !en || (acc_nxt == '0);
        load_ok  = set_ratio && (mult_in != '0) && (div_in != '0) && (mult_in <= div_in);
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            mult_q      <= WIDTH'(DEF_MULT);
            div_q       <= WIDTH'(DEF_DIV);
            acc_q       <= '0;
            skip_q      <= SKW'(SKIP_FIRST);
            pend_mult_q <= '0;
            pend_div_q  <= '0;
            pending     <= 1'b0;
            err         <= 1'b0;
            ce          <= 1'b0;
        end else begin
            acc_q  <= acc_nxt;
            skip_q <= skip_nxt;
            ce     <= hit && (skip_q == '0);

            // The boundary consumes the old pending value; a same-cycle request then re-arms pending.
            if (boundary && pending) begin
                mult_q  <= pend_mult_q;
                div_q   <= pend_div_q;
                pending <= 1'b0;
            end
            if (load_ok) begin
                pend_mult_q <= mult_in;
                pend_div_q  <= div_in;
                pending     <= 1'b1;
                err         <= 1'b0;
            end else if (set_ratio) begin
                err <= 1'b1;
            end
        end
    end

`ifdef SIM_CLK_CE_STATS_EN
    logic [31:0] count_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (ce) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign ce_count = count_q;
`else
    assign ce_count = '0;
`endif

    acc_in_range : assert property (@(posedge clk_in) disable iff (!rst_n) (acc_q < div_q));

endmodule

// File: tb/tb_sim_clk_ce_ratio.sv
// Scoreboard bench for sim_clk_ce_ratio: two instances (SKIP_FIRST 0 and 2) share stimulus
// and are compared every cycle against a closed-form floor(n*m/d) reference model.
module tb_sim_clk_ce_ratio;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        set_ratio = 1'b0;
    logic [15:0] mult_in = '0;
    logic [15:0] div_in = '0;

    logic        ce0, pending0, err0;
    logic        ce2, pending2, err2;
    logic [31:0] cnt0, cnt2;

    always #5 clk_in = ~clk_in;

    sim_clk_ce_ratio #(.WIDTH(16), .DEF_MULT(3), .DEF_DIV(5), .SKIP_FIRST(0)) u_dut0 (
        .clk_in(clk_in), .rst_n(rst_n), .en(en), .set_ratio(set_ratio),
        .mult_in(mult_in), .div_in(div_in),
        .ce(ce0), .pending(pending0), .err(err0), .ce_count(cnt0)
    );

    sim_clk_ce_ratio #(.WIDTH(16), .DEF_MULT(3), .DEF_DIV(5), .SKIP_FIRST(2)) u_dut2 (
        .clk_in(clk_in), .rst_n(rst_n), .en(en), .set_ratio(set_ratio),
        .mult_in(mult_in), .div_in(div_in),
        .ce(ce2), .pending(pending2), .err(err2), .ce_count(cnt2)
    );

    typedef struct {
        bit          ce0;
        bit          ce2;
        bit          pending;
        bit          err;
        int unsigned cnt0;
        int unsigned cnt2;
        bit          win;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int win0 = 0;
    int win2 = 0;

    task automatic check(input string name, input longint unsigned actual, input longint unsigned expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: within a ratio segment starting at acc = 0, enabled cycle n hits when
    // floor((n+1)*m/d) exceeds floor(n*m/d); the pattern restarts where (n+1)*m is a multiple of d.
    longint      m_n;
    int          m_mult, m_div, m_pm, m_pd;
    bit          m_pv, m_err;
    int          m_skip [2];
    bit          m_ce   [2];
    int unsigned m_cnt  [2];
    int          skips  [2] = '{0, 2};

    task automatic model_step(input bit r, input bit e, input bit s, input int m, input int d);
        bit hit, wrap;
        if (!r) begin
            m_mult = 3; m_div = 5; m_n = 0; m_pv = 0; m_err = 0;
            for (int i = 0; i < 2; i++) begin
                m_skip[i] = skips[i]; m_ce[i] = 0; m_cnt[i] = 0;
            end
        end else begin
`ifdef SIM_CLK_CE_STATS_EN
            for (int i = 0; i < 2; i++) m_cnt[i] += int'(m_ce[i]);
`endif
            if (e) begin
                hit  = ((m_n + 1) * m_mult) / m_div > (m_n * m_mult) / m_div;
                wrap = (((m_n + 1) * m_mult) % m_div) == 0;
            end else begin
                hit  = 0;
                wrap = 1;
            end
            for (int i = 0; i < 2; i++) begin
                m_ce[i] = e && hit && (m_skip[i] == 0);
                if (!e) m_skip[i] = skips[i];
                else if (hit && m_skip[i] > 0) m_skip[i]--;
            end
            m_n = wrap ? 0 : m_n + 1;
            if (wrap && m_pv) begin
                m_mult = m_pm; m_div = m_pd; m_pv = 0;
            end
            if (s) begin
                if (m != 0 && d != 0 && m <= d) begin
                    m_pm = m; m_pd = d; m_pv = 1; m_err = 0;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit s, input int m, input int d, input bit w);
        exp_t x;
        @(negedge clk_in);
        rst_n = r; en = e; set_ratio = s;
        mult_in = 16'(m); div_in = 16'(d);
        model_step(r, e, s, m, d);
        x.ce0 = m_ce[0]; x.ce2 = m_ce[1];
        x.pending = m_pv; x.err = m_err;
        x.cnt0 = m_cnt[0]; x.cnt2 = m_cnt[1];
        x.win = w;
        sb.push_back(x);
    endtask

    task automatic run(input int cycles, input bit w);
        for (int i = 0; i < cycles; i++) step(1, 1, 0, 0, 0, w);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk_in);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("ce_skip0", ce0, x.ce0);
                check("ce_skip2", ce2, x.ce2);
                check("pending", pending0, x.pending);
                check("pending_skip2", pending2, x.pending);
                check("err", err0, x.err);
                check("err_skip2", err2, x.err);
                check("ce_count_skip0", cnt0, x.cnt0);
                check("ce_count_skip2", cnt2, x.cnt2);
                if (x.win) begin
                    win0 += int'(ce0);
                    win2 += int'(ce2);
                end
            end
        end
    end

    initial begin : stimulus
        int r, e, s, m, d;
        longint unsigned exp_count;

        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0);

        // Default 3/5 pattern for 30 enabled cycles.
        run(30, 1);

        // One disabled cycle restarts skipping and the accumulator.
        step(1, 0, 0, 0, 0, 0);
        run(12, 0);

        // Ratio 1/2 requested mid-pattern waits for the acc wrap.
        step(0, 0, 0, 0, 0, 0);
        run(2, 0);
        step(1, 1, 1, 1, 2, 0);
        run(12, 0);

        // Illegal requests, then a legal 5/5.
        step(1, 1, 1, 6, 5, 0);
        run(3, 0);
        step(1, 1, 1, 0, 5, 0);
        run(4, 0);
        step(1, 1, 1, 5, 5, 0);
        run(12, 0);

        // Reset mid-pattern with a ratio pending.
        step(1, 1, 1, 2, 7, 0);
        step(0, 1, 0, 0, 0, 0);
        run(12, 0);

        // Long run at the default ratio for the pulse counter.
        step(0, 0, 0, 0, 0, 0);
        run(1000, 0);
        step(1, 0, 0, 0, 0, 0);
        @(posedge clk_in);
        #2;
`ifdef SIM_CLK_CE_STATS_EN
        exp_count = 600;
`else
        exp_count = 0;
`endif
        check("ce_count_1000", cnt0, exp_count);

        // Randomised traffic, legal and illegal loads, occasional disables and resets.
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 99) < 2) ? 0 : 1;
            e = ($urandom_range(0, 99) < 8) ? 0 : 1;
            s = ($urandom_range(0, 99) < 10) ? 1 : 0;
            d = $urandom_range(1, 12);
            m = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 14) : $urandom_range(1, d);
            if ($urandom_range(0, 19) == 0) d = 0;
            step(r[0], e[0], s[0], m, d, 0);
        end
        step(1, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk_in);
        #2;
        check("window_pulses_skip0", longint'(win0), 18);
        check("window_pulses_skip2", longint'(win2), 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
